// File: rtl/nios2_led_pio_pkg.sv
// Shared constants for the LED output PIO: register word offsets and STATUS bit positions.
package nios2_led_pio_pkg;

    localparam logic [2:0] ADDR_DATA         = 3'd0;
    localparam logic [2:0] ADDR_BLINK_MASK   = 3'd1;
    localparam logic [2:0] ADDR_BLINK_PERIOD = 3'd2;
    localparam logic [2:0] ADDR_STATUS       = 3'd3;
    localparam logic [2:0] ADDR_OUTSET       = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR     = 3'd5;

    localparam int unsigned STATUS_PHASE_BIT = 0;
    localparam int unsigned STATUS_EN_BIT    = 1;

endpackage

// File: rtl/nios2_led_blink_timer.sv
// Blink half-period timer: toggles o_phase every i_period clocks; i_period == 0 disables it.
module nios2_led_blink_timer #(
    parameter int unsigned PERIOD_W = 24
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [PERIOD_W-1:0] i_period,
    input  logic                i_restart,
    output logic                o_phase
);

    logic [PERIOD_W-1:0] r_cnt;
    logic                r_phase;
    logic [PERIOD_W-1:0] w_cnt_d;
    logic                w_phase_d;
    logic                w_terminal;

    assign w_terminal = (r_cnt == (i_period - PERIOD_W'(1)));

    always_comb begin
        w_cnt_d   = r_cnt + PERIOD_W'(1);
        w_phase_d = r_phase;
        // A restart (period rewrite) beats a coincident terminal count.
        if (i_restart || (i_period == '0)) begin
            w_cnt_d   = '0;
            w_phase_d = 1'b0;
        end else if (w_terminal) begin
            w_cnt_d   = '0;
            w_phase_d = ~r_phase;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_d;
            r_phase <= w_phase_d;
        end
    end

    assign o_phase = r_phase;

endmodule

// File: rtl/nios2_led_pio.sv
// Avalon-MM LED output port with set/clear strobes and a masked hardware blink engine.
module nios2_led_pio
    import nios2_led_pio_pkg::*;
#(
    parameter int unsigned     WIDTH       = 10,
    parameter int unsigned     PERIOD_W    = 24,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             chipselect,
    input  logic [2:0]       address,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    logic [WIDTH-1:0]    r_data;
    logic [WIDTH-1:0]    r_mask;
    logic [PERIOD_W-1:0] r_period;
    logic [31:0]         r_readdata;
    logic [WIDTH-1:0]    r_out;

    logic                w_wr;
    logic [WIDTH-1:0]    w_wdata;
    logic                w_restart;
    logic                w_phase;
    logic [31:0]         w_rdata;
    logic                w_unused_wdata;

    assign w_wr           = chipselect && !write_n;
    assign w_wdata        = writedata[WIDTH-1:0];
    assign w_restart      = w_wr && (address == ADDR_BLINK_PERIOD);
    assign w_unused_wdata = ^writedata;

    nios2_led_blink_timer #(
        .PERIOD_W (PERIOD_W)
    ) u_blink_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_period  (r_period),
        .i_restart (w_restart),
        .o_phase   (w_phase)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data   <= RESET_VALUE;
            r_mask   <= '0;
            r_period <= '0;
        end else if (w_wr) begin
            case (address)
                ADDR_DATA:         r_data   <= w_wdata;
                ADDR_BLINK_MASK:   r_mask   <= w_wdata;
                ADDR_BLINK_PERIOD: r_period <= writedata[PERIOD_W-1:0];
                ADDR_OUTSET:       r_data   <= r_data | w_wdata;
                ADDR_OUTCLEAR:     r_data   <= r_data & ~w_wdata;
                default:           ;
            endcase
        end
    end

    // Read mux sees pre-write register values when a write lands on the same edge.
    always_comb begin
        w_rdata = '0;
        case (address)
            ADDR_DATA:         w_rdata[WIDTH-1:0]    = r_data;
            ADDR_BLINK_MASK:   w_rdata[WIDTH-1:0]    = r_mask;
            ADDR_BLINK_PERIOD: w_rdata[PERIOD_W-1:0] = r_period;
            ADDR_STATUS: begin
                w_rdata[STATUS_PHASE_BIT] = w_phase;
                w_rdata[STATUS_EN_BIT]    = (r_period != '0);
            end
            default:           w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_readdata <= '0;
            r_out      <= RESET_VALUE;
        end else begin
            r_readdata <= w_rdata;
            r_out      <= r_data & ~(r_mask & {WIDTH{w_phase}});
        end
    end

    assign readdata = r_readdata;
    assign out_port = r_out;

endmodule

// File: tb/tb_nios2_led_pio.sv
// Directed self-checking bench for nios2_led_pio: register access, set/clear, blink timing, reset.
module tb_nios2_led_pio;

    logic        clk;
    logic        reset_n;
    logic        chipselect;
    logic [2:0]  address;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [9:0]  out_port;

    int n_checks = 0;
    int n_pass   = 0;

    nios2_led_pio #(
        .WIDTH       (10),
        .PERIOD_W    (24),
        .RESET_VALUE (10'h000)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .chipselect (chipselect),
        .address    (address),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Called at a negedge; write lands on the next posedge, returns at the following negedge.
    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        @(negedge clk);
    endtask

    task automatic bus_read(input logic [2:0] a, input logic [31:0] exp, input string tag);
        address = a;
        @(posedge clk);
        @(negedge clk);
        check_eq(tag, readdata, exp);
    endtask

    initial begin
        logic [31:0] exp_out;
        logic [31:0] exp_st;
        reset_n    = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 3'd0;
        writedata  = '0;
        repeat (2) @(negedge clk);
        check_eq("reset_out_port", 32'(out_port), 32'h0);
        check_eq("reset_readdata", readdata, 32'h0);
        reset_n = 1'b1;
        @(negedge clk);

        // 1. asynchronous reset mid-clock
        bus_write(3'd0, 32'h155);
        bus_read(3'd0, 32'h155, "pre_reset_data");
        check_eq("pre_reset_out", 32'(out_port), 32'h155);
        #2 reset_n = 1'b0;
        #1;
        check_eq("async_reset_readdata", readdata, 32'h0);
        check_eq("async_reset_out", 32'(out_port), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        bus_read(3'd3, 32'h0, "status_after_reset");
        bus_read(3'd0, 32'h0, "data_after_reset");

        // 2. DATA, OUTCLEAR, OUTSET with junk upper bits
        bus_write(3'd0, 32'hFFFF_FFFF);
        bus_write(3'd5, 32'hFFFF_FC0F);
        bus_write(3'd4, 32'hFFFF_FC01);
        check_eq("out_lags_one_edge", 32'(out_port), 32'h3F0);
        @(negedge clk);
        check_eq("out_after_set", 32'(out_port), 32'h3F1);
        bus_read(3'd0, 32'h3F1, "data_after_setclr");
        bus_read(3'd4, 32'h0, "read_outset");
        bus_read(3'd5, 32'h0, "read_outclear");

        // 3. blink with period 4
        bus_write(3'd0, 32'h0FF);
        bus_write(3'd1, 32'h00F);
        bus_write(3'd2, 32'd4);
        address = 3'd3;
        for (int i = 1; i <= 13; i++) begin
            @(negedge clk);
            exp_out = (((i - 1) / 4) % 2 == 1) ? 32'h0F0 : 32'h0FF;
            exp_st  = (((i - 1) / 4) % 2 == 1) ? 32'h3 : 32'h2;
            check_eq($sformatf("blink_out_%0d", i), 32'(out_port), exp_out);
            check_eq($sformatf("blink_status_%0d", i), readdata, exp_st);
        end

        // 4. period rewrite while phase=1 restarts the engine
        bus_write(3'd2, 32'd4);
        check_eq("rewrite_out_before", 32'(out_port), 32'h0F0);
        address = 3'd3;
        for (int j = 1; j <= 5; j++) begin
            @(negedge clk);
            exp_out = (j == 5) ? 32'h0F0 : 32'h0FF;
            exp_st  = (j == 5) ? 32'h3 : 32'h2;
            check_eq($sformatf("restart_out_%0d", j), 32'(out_port), exp_out);
            check_eq($sformatf("restart_status_%0d", j), readdata, exp_st);
        end

        // 5. blink disabled: out_port follows DATA despite a full mask
        bus_write(3'd2, 32'd0);
        bus_write(3'd1, 32'h3FF);
        bus_write(3'd0, 32'h2AA);
        address = 3'd3;
        @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check_eq($sformatf("disabled_out_%0d", k), 32'(out_port), 32'h2AA);
            check_eq($sformatf("disabled_status_%0d", k), readdata, 32'h0);
        end
        bus_read(3'd1, 32'h3FF, "read_mask");
        bus_read(3'd2, 32'h0, "read_period");

        // 6. unmapped / read-only addresses and same-edge write/read
        bus_write(3'd6, 32'hFFFF);
        bus_write(3'd7, 32'hFFFF);
        bus_write(3'd3, 32'hFFFF);
        bus_read(3'd3, 32'h0, "status_write_ignored");
        bus_read(3'd6, 32'h0, "read_addr6");
        bus_read(3'd7, 32'h0, "read_addr7");
        bus_read(3'd0, 32'h2AA, "data_untouched");
        bus_write(3'd0, 32'h155);
        check_eq("same_edge_old", readdata, 32'h2AA);
        @(negedge clk);
        check_eq("same_edge_new", readdata, 32'h155);

        // reset in the middle of blinking
        bus_write(3'd2, 32'd1);
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check_eq("midblink_reset_out", 32'(out_port), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        bus_read(3'd3, 32'h0, "midblink_status");
        bus_read(3'd1, 32'h0, "midblink_mask");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/nios2_led_pio.md
Name: nios2_led_pio

Overview:
Avalon-MM slave output port (write direction) driving board LEDs from the Nios II system.
- Holds a software-written output data register, with atomic set/clear strobes.
- Adds a hardware blink engine: masked bits toggle off/on at a programmable half-period, so no CPU polling loop is needed.
- Sits on the system interconnect beside the switch input port; shares its register read timing and reset style.

Parameters:
WIDTH, 10, number of output bits (LEDs)
PERIOD_W, 24, width of blink half-period register/counter
RESET_VALUE, 0, reset value of DATA register (WIDTH bits)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
chipselect  in  1  Avalon slave select
address  in  3  word address
write_n  in  1  active-low write strobe, qualified by chipselect
writedata  in  32  write data
readdata  out  32  registered read data
out_port  out  WIDTH  LED drive, registered

Behaviour:
- Reset is reset_n, asynchronous, active-low; clock is clk. All registers clear on reset:
  - DATA=RESET_VALUE, BLINK_MASK=0, BLINK_PERIOD=0, cnt=0, phase=0.
  - readdata=0, out_port=RESET_VALUE.
- Write accepted on a rising edge with chipselect=1 and write_n=0. No wait states. Unused upper writedata bits are ignored.
- Register map (word addresses):
  - 0 DATA, R/W: DATA <= writedata[WIDTH-1:0].
  - 1 BLINK_MASK, R/W, WIDTH bits.
  - 2 BLINK_PERIOD, R/W, PERIOD_W bits; a write also forces cnt=0 and phase=0 on the same edge.
  - 3 STATUS, R only: bit0=phase, bit1=(BLINK_PERIOD!=0); writes ignored.
  - 4 OUTSET, W: DATA <= DATA | writedata[WIDTH-1:0]; reads return 0.
  - 5 OUTCLEAR, W: DATA <= DATA & ~writedata[WIDTH-1:0]; reads return 0.
  - 6-7: reads return 0, writes ignored.
- Read path:
  - readdata updated every clk from address, zero-extended to 32 bits. Independent of chipselect/read, so read latency is 1 cycle.
  - Value sampled is the pre-write register content when a write occurs on the same edge.
- Blink engine:
  - BLINK_PERIOD==0: cnt held 0, phase held 0 (blink disabled).
  - Otherwise cnt increments each clk. When cnt==BLINK_PERIOD-1: cnt<=0 and phase toggles.
  - BLINK_PERIOD==1 toggles phase every clk.
  - If BLINK_PERIOD is written to a value <= current cnt, the reset-on-write rule applies, so no wrap-around overrun can occur.
- Output:
  - out_port <= DATA & ~(BLINK_MASK & {WIDTH{phase}}), registered.
  - A DATA write at edge N appears on out_port at edge N+1.
  - A phase toggle at edge N appears on out_port at edge N+1.
- Simultaneous events:
  - A BLINK_PERIOD write on the same edge as a terminal count: the write wins (cnt=0, phase=0).
  - Only one register is written per cycle (single address), so no set/clear conflict exists.
- Reset mid-blink: immediate, asynchronous return to reset values. The blink engine restarts disabled.

Decomposition:
- Shared package: register offset constants ADDR_DATA=0, ADDR_BLINK_MASK=1, ADDR_BLINK_PERIOD=2, ADDR_STATUS=3, ADDR_OUTSET=4, ADDR_OUTCLEAR=5; STATUS bit indices.
- One natural sub-module: nios2_led_blink_timer. Inputs: period, restart pulse, clk, reset_n. Output: phase.
- Register file, read mux and output register stay in the top module.

Test Plan:
1. Reset with reset_n=0 mid-clock -> readdata=0 and out_port=0 immediately; after release, a read of address 3 returns 0.
2. Write DATA=0x3FF, then OUTCLEAR 0x00F, then OUTSET 0x001. Required:
   - Read of addr 0 returns 0x3F1.
   - out_port=0x3F1 one cycle after the last write edge.
   - Upper writedata bits (e.g. 0xFFFFFC00) have no effect.
3. DATA=0x0FF, BLINK_MASK=0x00F, BLINK_PERIOD=4. Required:
   - out_port alternates 0x0FF for 4 cycles, then 0x0F0 for 4 cycles.
   - STATUS bit0 matches phase; bit1=1.
4. During blinking with phase=1, write BLINK_PERIOD=4 -> phase returns to 0, out_port=0x0FF on the next cycle, and the next toggle occurs exactly 4 cycles after the write.
5. BLINK_PERIOD=0 with BLINK_MASK=0x3FF -> out_port constantly equals DATA; STATUS reads 0.
6. Read addresses 4, 5, 6, 7 after writes -> readdata=0; a same-edge write and read of DATA returns the old value, and the new value on the following read.
